day01_rotation_parser: RTL and testbench

Byte-stream front end for the Day 1 dial solver. It consumes puzzle input one ASCII byte at a time, parses each line of the form direction letter + decimal count + newline, and presents one rotation command per line on a valid/ready interface. The solver's command port sits directly downstream: `dir` 0 = left, 1 = right; `steps` is a 32-bit count. The block also reports malformed input through sticky error flags and counts emitted records.

---
 rtl/day01_rotation_parser.sv | 146 ++++++++++++++
 tb/tb_day01_rotation_parser.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/day01_rotation_parser.sv
// day01_rotation_parser
//
// Byte-stream front end for the Day 1 dial solver. It consumes ASCII puzzle
// input one byte per cycle and parses lines of the form
// <'L'|'R'><decimal count>'\n'. Each well-formed line becomes one rotation
// command on a valid/ready output port.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_data  input byte stream (in_data is ASCII)
//   in_ready          byte accepted when in_valid && in_ready; depends on state only
//   out_valid         command available; held until out_ready
//   out_dir           0 = 'L', 1 = 'R'
//   out_steps         parsed count, saturated at 0xFFFFFFFF
//   out_ready         downstream accepts the command
//   record_count      commands handed off, wraps modulo 2^16
//   err_syntax        sticky: unexpected byte seen
//   err_overflow      sticky: a count exceeded 2^32-1
module day01_rotation_parser (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_dir,
  output logic [31:0] out_steps,
  input  logic        out_ready,
  output logic [15:0] record_count,
  output logic        err_syntax,
  output logic        err_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGITS,
    S_EMIT,
    S_SKIP
  } state_t;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  state_t      state;
  logic [31:0] acc;
  logic        nd;
  logic        dir;

  // acc*10 + d at 36 bits. The product of a 32-bit value and 10 always fits,
  // so any bit above bit 31 means overflow and the result saturates.
  // Returns {overflow, value}.
  function automatic logic [32:0] mac_sat(input logic [31:0] a, input logic [3:0] d);
    logic [35:0] p;
    p = ({4'd0, a} * 36'd10) + {32'd0, d};
    if (p[35:32] != 4'd0) begin
      return {1'b1, 32'hFFFF_FFFF};
    end
    return {1'b0, p[31:0]};
  endfunction

  logic        take;
  logic        is_digit;
  logic [32:0] mac_res;

  assign in_ready = (state != S_EMIT);
  assign take     = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign mac_res  = mac_sat(acc, in_data[3:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      acc          <= '0;
      nd           <= 1'b0;
      dir          <= 1'b0;
      out_valid    <= 1'b0;
      out_dir      <= 1'b0;
      out_steps    <= '0;
      record_count <= '0;
      err_syntax   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            if (in_data == CH_L || in_data == CH_R) begin
              dir   <= (in_data == CH_R);
              acc   <= '0;
              nd    <= 1'b0;
              state <= S_DIGITS;
            end else if (in_data != CH_LF && in_data != CH_CR) begin
              err_syntax <= 1'b1;
              state      <= S_SKIP;
            end
          end
        end

        S_DIGITS: begin
          if (take) begin
            if (is_digit) begin
              acc <= mac_res[31:0];
              nd  <= 1'b1;
              if (mac_res[32]) begin
                err_overflow <= 1'b1;
              end
            end else if (in_data == CH_LF) begin
              if (nd) begin
                out_steps <= acc;
                out_dir   <= dir;
                out_valid <= 1'b1;
                state     <= S_EMIT;
              end else begin
                // Direction letter with no count: drop the line.
                err_syntax <= 1'b1;
                state      <= S_IDLE;
              end
            end else if (in_data != CH_CR) begin
              err_syntax <= 1'b1;
              state      <= S_SKIP;
            end
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            record_count <= record_count + 16'd1;
            state        <= S_IDLE;
          end
        end

        S_SKIP: begin
          // Resynchronise on the next line; the '\n' itself is consumed.
          if (take && in_data == CH_LF) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day01_rotation_parser.sv
module tb_day01_rotation_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_dir;
  logic [31:0] out_steps;
  logic        out_ready;
  logic [15:0] record_count;
  logic        err_syntax;
  logic        err_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  int          xfers;
  logic        last_dir;
  logic [31:0] last_steps;

  day01_rotation_parser dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_dir      (out_dir),
    .out_steps    (out_steps),
    .out_ready    (out_ready),
    .record_count (record_count),
    .err_syntax   (err_syntax),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  // Records every command transfer seen on the output port.
  always @(posedge clk) begin
    if (rst) begin
      xfers <= 0;
    end else if (out_valid && out_ready) begin
      xfers      <= xfers + 1;
      last_dir   <= out_dir;
      last_steps <= out_steps;
    end
  end

  // Drives one byte at a negedge and returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int wait_cyc;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout in_ready got %0b want 1 (byte %h)", in_ready, b);
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    n_cmp++;
    if ({out_valid, out_dir, out_steps, record_count, err_syntax, err_overflow, in_ready}
        !== {1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_vals got v=%0b d=%0b s=%0d rc=%0d es=%0b eo=%0b ir=%0b want 0 0 0 0 0 0 1",
               out_valid, out_dir, out_steps, record_count, err_syntax, err_overflow, in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send_str("L68\n");
    // One cycle after the '\n' was accepted.
    n_cmp++;
    if ({out_valid, out_dir, out_steps} !== {1'b1, 1'b0, 32'd68}) begin
      n_bad++;
      $display("FAIL basic_cmd got v=%0b d=%0b s=%0d want 1 0 68", out_valid, out_dir, out_steps);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, record_count} !== {1'b0, 1'b1, 16'd1} || xfers !== 1) begin
      n_bad++;
      $display("FAIL basic_after got v=%0b ir=%0b rc=%0d x=%0d want 0 1 1 1",
               out_valid, in_ready, record_count, xfers);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send_str("R1000\r\n");
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({out_valid, out_dir, out_steps, in_ready} !== {1'b1, 1'b1, 32'd1000, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got v=%0b d=%0b s=%0d ir=%0b want 1 1 1000 0",
                 i, out_valid, out_dir, out_steps, in_ready);
      end
      if (i == 5) out_ready = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if ({out_valid, in_ready, record_count} !== {1'b0, 1'b1, 16'd1} || xfers !== 1) begin
      n_bad++;
      $display("FAIL bp_release got v=%0b ir=%0b rc=%0d x=%0d want 0 1 1 1",
               out_valid, in_ready, record_count, xfers);
    end
  endtask

  task automatic test_recovery();
    do_reset();
    out_ready = 1'b1;
    send_str("X5\nR3\n");
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (err_syntax !== 1'b1) begin
      n_bad++;
      $display("FAIL rec_err got %0b want 1", err_syntax);
    end
    n_cmp++;
    if (xfers !== 1 || last_dir !== 1'b1 || last_steps !== 32'd3 || record_count !== 16'd1) begin
      n_bad++;
      $display("FAIL rec_cmd got x=%0d d=%0b s=%0d rc=%0d want 1 1 3 1",
               xfers, last_dir, last_steps, record_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b1;
    send_str("R4294967295\n");
    n_cmp++;
    if ({out_valid, out_steps, err_overflow} !== {1'b1, 32'hFFFF_FFFF, 1'b0}) begin
      n_bad++;
      $display("FAIL ovf_max got v=%0b s=%h eo=%0b want 1 ffffffff 0", out_valid, out_steps, err_overflow);
    end
    send_str("R4294967296\n");
    n_cmp++;
    if ({out_valid, out_steps, err_overflow} !== {1'b1, 32'hFFFF_FFFF, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_sat got v=%0b s=%h eo=%0b want 1 ffffffff 1", out_valid, out_steps, err_overflow);
    end
    send_str("L7\n");
    n_cmp++;
    if ({out_valid, out_dir, out_steps, err_overflow} !== {1'b1, 1'b0, 32'd7, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_next got v=%0b d=%0b s=%0d eo=%0b want 1 0 7 1",
               out_valid, out_dir, out_steps, err_overflow);
    end
    @(negedge clk);
    n_cmp++;
    if (record_count !== 16'd3 || xfers !== 3) begin
      n_bad++;
      $display("FAIL ovf_count got rc=%0d x=%0d want 3 3", record_count, xfers);
    end
  endtask

  task automatic test_edge_lines();
    do_reset();
    out_ready = 1'b1;
    send_str("\n\n");
    n_cmp++;
    if ({err_syntax, in_ready, out_valid} !== {1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL edge_blank got es=%0b ir=%0b v=%0b want 0 1 0", err_syntax, in_ready, out_valid);
    end
    send_str("L\n");
    n_cmp++;
    if ({err_syntax, out_valid} !== {1'b1, 1'b0} || xfers !== 0) begin
      n_bad++;
      $display("FAIL edge_nodigit got es=%0b v=%0b x=%0d want 1 0 0", err_syntax, out_valid, xfers);
    end
    send_str("L0\n");
    n_cmp++;
    if ({out_valid, out_dir, out_steps} !== {1'b1, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL edge_zero got v=%0b d=%0b s=%0d want 1 0 0", out_valid, out_dir, out_steps);
    end
    @(negedge clk);
    n_cmp++;
    if (record_count !== 16'd1) begin
      n_bad++;
      $display("FAIL edge_count got %0d want 1", record_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    send_str("X");
    send_str("\nR12");
    do_reset();
    n_cmp++;
    if ({out_valid, out_dir, out_steps, record_count, err_syntax, err_overflow, in_ready}
        !== {1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset got v=%0b d=%0b s=%0d rc=%0d es=%0b eo=%0b ir=%0b want 0 0 0 0 0 0 1",
               out_valid, out_dir, out_steps, record_count, err_syntax, err_overflow, in_ready);
    end
    // A pending command is discarded by reset.
    out_ready = 1'b0;
    send_str("R9\n");
    do_reset();
    n_cmp++;
    if ({out_valid, in_ready, out_steps} !== {1'b0, 1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL mid_pending got v=%0b ir=%0b s=%0d want 0 1 0", out_valid, in_ready, out_steps);
    end
    out_ready = 1'b1;
    send_str("L5\n");
    n_cmp++;
    if ({out_valid, out_dir, out_steps} !== {1'b1, 1'b0, 32'd5}) begin
      n_bad++;
      $display("FAIL mid_after got v=%0b d=%0b s=%0d want 1 0 5", out_valid, out_dir, out_steps);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    send_str("R2\nL31\nR4\n");
    @(negedge clk);
    n_cmp++;
    if (record_count !== 16'd3 || xfers !== 3 || last_dir !== 1'b1 || last_steps !== 32'd4) begin
      n_bad++;
      $display("FAIL b2b got rc=%0d x=%0d d=%0b s=%0d want 3 3 1 4",
               record_count, xfers, last_dir, last_steps);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_recovery();
    test_overflow();
    test_edge_lines();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
